// File: rtl/bldc_startup_sequencer.sv
// Start/stop sequencer for the BLDC velocity loop: align, settle, zero, ramp, run, with fault latching.
// Optional stall detection is compiled in when STALL_DETECT_EN is defined.
module bldc_startup_sequencer #(
   parameter int          ALIGN_CYCLES  = 50000,
   parameter int          SETTLE_CYCLES = 10000,
   parameter logic [15:0] ALIGN_GAIN    = 16'd2000,
   parameter logic [15:0] RAMP_STEP     = 16'd8,
   parameter int          RAMP_INTERVAL = 1000,
   parameter int          STALL_CYCLES  = 200000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic [15:0] target_velocity,
   input  logic        encoder_change,
   input  logic        fault_in,
   input  logic        clear_fault,
   output logic        enable,
   output logic        apply_initial_commutation,
   output logic        reset_encoder_count,
   output logic        gain_override_en,
   output logic [15:0] gain_override,
   output logic [15:0] velocity_setpoint,
   output logic        running,
   output logic        fault,
   output logic [1:0]  fault_code
);

   localparam int PH_MAX = (ALIGN_CYCLES > SETTLE_CYCLES)
                         ? ((ALIGN_CYCLES > RAMP_INTERVAL) ? ALIGN_CYCLES : RAMP_INTERVAL)
                         : ((SETTLE_CYCLES > RAMP_INTERVAL) ? SETTLE_CYCLES : RAMP_INTERVAL);
   localparam int PH_W = $clog2(PH_MAX + 1);
   localparam logic [PH_W-1:0] ALIGN_LAST  = PH_W'(ALIGN_CYCLES - 1);
   localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
   localparam logic [PH_W-1:0] RAMP_LAST   = PH_W'(RAMP_INTERVAL - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ALIGN, S_SETTLE, S_ZERO, S_RAMP, S_RUN, S_FAULT
   } state_t;

   state_t          state, state_n;
   logic [PH_W-1:0] phase_cnt, phase_n;
   logic [15:0]     sp_n;
   logic [1:0]      code_n;
   logic            stall;

   // Sum is widened to 17 bits so a large step near full scale clamps to the target instead of wrapping.
   function automatic logic [15:0] ramp_next(input logic [15:0] sp, input logic [15:0] tgt);
      logic [16:0] sum;
      sum = {1'b0, sp} + {1'b0, RAMP_STEP};
      if (sum > {1'b0, tgt})
         ramp_next = tgt;
      else
         ramp_next = sum[15:0];
   endfunction

`ifdef STALL_DETECT_EN
   localparam int ST_W = $clog2(STALL_CYCLES + 1);
   localparam logic [ST_W-1:0] STALL_MAX = ST_W'(STALL_CYCLES);

   logic [ST_W-1:0] stall_cnt, stall_cnt_n;
   logic            counting;

   assign counting = (state == S_RAMP) || (state == S_RUN);

   // Held at zero outside RAMP/RUN, so entering RAMP always starts a fresh window.
   always_comb begin
      stall_cnt_n = stall_cnt;
      stall       = 1'b0;
      if (!counting)
         stall_cnt_n = '0;
      else if (encoder_change)
         stall_cnt_n = '0;
      else if (stall_cnt != STALL_MAX)
         stall_cnt_n = stall_cnt + 1'b1;
      if (counting && !encoder_change && (stall_cnt_n == STALL_MAX))
         stall = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_cnt <= '0;
      else
         stall_cnt <= stall_cnt_n;
   end
`else
   logic unused_encoder_change;
   assign unused_encoder_change = encoder_change;
   assign stall = 1'b0;
`endif

   always_comb begin
      state_n = state;
      phase_n = '0;
      sp_n    = velocity_setpoint;
      code_n  = fault_code;
      if (fault_in) begin
         state_n = S_FAULT;
         code_n  = 2'b01;
      end else if (stall) begin
         state_n = S_FAULT;
         code_n  = 2'b10;
      end else if (stop && (state != S_IDLE) && (state != S_FAULT)) begin
         state_n = S_IDLE;
      end else begin
         case (state)
            S_IDLE:   if (start) state_n = S_ALIGN;
            S_ALIGN: begin
               phase_n = phase_cnt + 1'b1;
               if (phase_cnt == ALIGN_LAST) state_n = S_SETTLE;
            end
            S_SETTLE: begin
               phase_n = phase_cnt + 1'b1;
               if (phase_cnt == SETTLE_LAST) state_n = S_ZERO;
            end
            S_ZERO:   state_n = S_RAMP;
            S_RAMP: begin
               if (velocity_setpoint == target_velocity) begin
                  state_n = S_RUN;
               end else if (phase_cnt == RAMP_LAST) begin
                  sp_n    = ramp_next(velocity_setpoint, target_velocity);
                  phase_n = '0;
               end else begin
                  phase_n = phase_cnt + 1'b1;
               end
            end
            S_RUN:    sp_n = target_velocity;
            S_FAULT: begin
               if (clear_fault) begin
                  state_n = S_IDLE;
                  code_n  = 2'b00;
               end
            end
            default:  state_n = S_IDLE;
         endcase
      end
      if (state_n != state)
         phase_n = '0;
      if ((state_n != S_RAMP) && (state_n != S_RUN))
         sp_n = '0;
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state                     <= S_IDLE;
         phase_cnt                 <= '0;
         velocity_setpoint         <= '0;
         fault_code                <= 2'b00;
         enable                    <= 1'b0;
         apply_initial_commutation <= 1'b0;
         reset_encoder_count       <= 1'b0;
         gain_override_en          <= 1'b0;
         gain_override             <= '0;
         running                   <= 1'b0;
         fault                     <= 1'b0;
      end else begin
         state                     <= state_n;
         phase_cnt                 <= phase_n;
         velocity_setpoint         <= sp_n;
         fault_code                <= code_n;
         enable                    <= (state_n == S_ALIGN) || (state_n == S_SETTLE) ||
                                      (state_n == S_ZERO)  || (state_n == S_RAMP)   ||
                                      (state_n == S_RUN);
         apply_initial_commutation <= (state_n == S_ALIGN);
         reset_encoder_count       <= (state_n == S_ZERO);
         gain_override_en          <= (state_n == S_ALIGN) || (state_n == S_SETTLE);
         gain_override             <= ((state_n == S_ALIGN) || (state_n == S_SETTLE)) ? ALIGN_GAIN : 16'h0000;
         running                   <= (state_n == S_RUN);
         fault                     <= (state_n == S_FAULT);
      end
   end

endmodule

// File: tb/tb_bldc_startup_sequencer.sv
// Scoreboard bench for bldc_startup_sequencer: directed stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them against two instances (small and large RAMP_STEP).
module tb_bldc_startup_sequencer;

   localparam logic [15:0] GAIN = 16'd2000;
   // flag order: {enable, apply_initial_commutation, reset_encoder_count, gain_override_en, running, fault}
   localparam logic [5:0] F_IDLE   = 6'b000000;
   localparam logic [5:0] F_ALIGN  = 6'b110100;
   localparam logic [5:0] F_SETTLE = 6'b100100;
   localparam logic [5:0] F_ZERO   = 6'b101000;
   localparam logic [5:0] F_RAMP   = 6'b100000;
   localparam logic [5:0] F_RUN    = 6'b100010;
   localparam logic [5:0] F_FAULT  = 6'b000001;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0, start2 = 1'b0, stop = 1'b0;
   logic        encoder_change = 1'b0, fault_in = 1'b0, clear_fault = 1'b0;
   logic [15:0] target = 16'd35, target2 = 16'hFFFF;

   logic        en1, ap1, re1, ge1, ru1, fa1;
   logic [15:0] g1, sp1;
   logic [1:0]  fc1;
   logic        en2, ap2, re2, ge2, ru2, fa2;
   logic [15:0] g2, sp2;
   logic [1:0]  fc2;

   bldc_startup_sequencer #(
      .ALIGN_CYCLES(4), .SETTLE_CYCLES(3), .ALIGN_GAIN(GAIN),
      .RAMP_STEP(16'd10), .RAMP_INTERVAL(2), .STALL_CYCLES(20)
   ) dut1 (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .target_velocity(target), .encoder_change(encoder_change),
      .fault_in(fault_in), .clear_fault(clear_fault),
      .enable(en1), .apply_initial_commutation(ap1), .reset_encoder_count(re1),
      .gain_override_en(ge1), .gain_override(g1), .velocity_setpoint(sp1),
      .running(ru1), .fault(fa1), .fault_code(fc1)
   );

   bldc_startup_sequencer #(
      .ALIGN_CYCLES(4), .SETTLE_CYCLES(3), .ALIGN_GAIN(GAIN),
      .RAMP_STEP(16'h8000), .RAMP_INTERVAL(2), .STALL_CYCLES(20)
   ) dut2 (
      .clk(clk), .reset(reset), .start(start2), .stop(stop),
      .target_velocity(target2), .encoder_change(encoder_change),
      .fault_in(fault_in), .clear_fault(clear_fault),
      .enable(en2), .apply_initial_commutation(ap2), .reset_encoder_count(re2),
      .gain_override_en(ge2), .gain_override(g2), .velocity_setpoint(sp2),
      .running(ru2), .fault(fa2), .fault_code(fc2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          at;
      int          unit;
      string       name;
      logic [5:0]  fl;
      logic [15:0] sp;
      logic [1:0]  code;
   } exp_t;

   exp_t q[$];
   int vectors = 0;
   int miscompares = 0;

   task automatic expect_at(input int d, input int unit, input string nm,
                            input logic [5:0] fl, input logic [15:0] sp, input logic [1:0] code);
      exp_t e;
      e.at = cyc + d; e.unit = unit; e.name = nm; e.fl = fl; e.sp = sp; e.code = code;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   exp_t        mon_e;
   logic [39:0] mon_act, mon_exp;
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].at <= cyc) begin
         mon_e = q.pop_front();
         if (mon_e.unit == 0)
            mon_act = {en1, ap1, re1, ge1, ru1, fa1, g1, sp1, fc1};
         else
            mon_act = {en2, ap2, re2, ge2, ru2, fa2, g2, sp2, fc2};
         mon_exp = {mon_e.fl, (mon_e.fl[2] ? GAIN : 16'h0000), mon_e.sp, mon_e.code};
         vectors++;
         if (mon_e.at != cyc || mon_act !== mon_exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d (due %0d): got flags=%b gain=%h sp=%h code=%b, want flags=%b gain=%h sp=%h code=%b",
                     mon_e.name, cyc, mon_e.at, mon_act[39:34], mon_act[33:18], mon_act[17:2], mon_act[1:0],
                     mon_exp[39:34], mon_exp[33:18], mon_exp[17:2], mon_exp[1:0]);
         end
      end
   end

   initial begin
      int guard;
      logic [5:0]  fl;
      logic [15:0] sp;

      tick(); tick();
      expect_at(0, 0, "reset_state_u1", F_IDLE, 16'h0, 2'b00);
      expect_at(0, 1, "reset_state_u2", F_IDLE, 16'h0, 2'b00);
      tick();
      reset = 1'b1;
      tick();

      // Normal start to RUN, then (with stall detection) a stall fault from lack of encoder edges.
      start = 1'b1;
      for (int d = 1; d <= 18; d++) begin
         sp = 16'd0;
         if (d <= 4)       fl = F_ALIGN;
         else if (d <= 7)  fl = F_SETTLE;
         else if (d == 8)  fl = F_ZERO;
         else if (d == 18) fl = F_RUN;
         else              fl = F_RAMP;
         if (d >= 17)      sp = 16'd35;
         else if (d >= 15) sp = 16'd30;
         else if (d >= 13) sp = 16'd20;
         else if (d >= 11) sp = 16'd10;
         expect_at(d, 0, "normal_seq", fl, sp, 2'b00);
      end
      expect_at(28, 0, "run_pre_stall", F_RUN, 16'd35, 2'b00);
`ifdef STALL_DETECT_EN
      expect_at(29, 0, "stall_fault", F_FAULT, 16'd0, 2'b10);
`else
      expect_at(29, 0, "no_stall_fault", F_RUN, 16'd35, 2'b00);
`endif
      expect_at(30, 0, "stop_or_clear_idle", F_IDLE, 16'd0, 2'b00);
      tick();
      start = 1'b0;
      repeat (28) tick();
      stop = 1'b1; clear_fault = 1'b1;
      tick();
      stop = 1'b0; clear_fault = 1'b0;
      tick();

      // Encoder edges every 15 cycles keep RUN alive.
      start = 1'b1;
      expect_at(40, 0, "enc_run_40", F_RUN, 16'd35, 2'b00);
      expect_at(60, 0, "enc_run_60", F_RUN, 16'd35, 2'b00);
      expect_at(61, 0, "enc_stop_idle", F_IDLE, 16'd0, 2'b00);
      for (int i = 1; i <= 60; i++) begin
         tick();
         start = 1'b0;
         encoder_change = ((i % 15) == 14);
      end
      encoder_change = 1'b0;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();

      // Stop during RAMP at setpoint 20.
      start = 1'b1;
      expect_at(13, 0, "ramp_sp20", F_RAMP, 16'd20, 2'b00);
      expect_at(14, 0, "stop_in_ramp", F_IDLE, 16'd0, 2'b00);
      tick();
      start = 1'b0;
      repeat (12) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();

      // External fault in SETTLE, blocked clear, real clear with start held, fault from IDLE.
      start = 1'b1;
      expect_at(5,  0, "settle_entry", F_SETTLE, 16'd0, 2'b00);
      expect_at(6,  0, "ext_fault", F_FAULT, 16'd0, 2'b01);
      expect_at(8,  0, "fault_latched", F_FAULT, 16'd0, 2'b01);
      expect_at(9,  0, "clear_blocked", F_FAULT, 16'd0, 2'b01);
      expect_at(10, 0, "clear_ok", F_IDLE, 16'd0, 2'b00);
      expect_at(11, 0, "restart_held", F_ALIGN, 16'd0, 2'b00);
      expect_at(12, 0, "stop_align", F_IDLE, 16'd0, 2'b00);
      expect_at(13, 0, "fault_from_idle", F_FAULT, 16'd0, 2'b01);
      expect_at(14, 0, "clear_idle", F_IDLE, 16'd0, 2'b00);
      tick();
      start = 1'b0;
      repeat (4) tick();
      fault_in = 1'b1;
      tick();
      fault_in = 1'b0;
      tick(); tick();
      fault_in = 1'b1; clear_fault = 1'b1;
      tick();
      fault_in = 1'b0; start = 1'b1;
      tick();
      clear_fault = 1'b0;
      tick();
      start = 1'b0; stop = 1'b1;
      tick();
      stop = 1'b0; fault_in = 1'b1;
      tick();
      fault_in = 1'b0; clear_fault = 1'b1;
      tick();
      clear_fault = 1'b0;
      tick();

      // Asynchronous reset during ALIGN, then a full-length restart.
      start = 1'b1;
      expect_at(1, 0, "align_before_rst", F_ALIGN, 16'd0, 2'b00);
      expect_at(2, 0, "async_reset", F_IDLE, 16'd0, 2'b00);
      expect_at(4, 0, "idle_after_rst", F_IDLE, 16'd0, 2'b00);
      expect_at(5, 0, "realign_first", F_ALIGN, 16'd0, 2'b00);
      expect_at(8, 0, "realign_last", F_ALIGN, 16'd0, 2'b00);
      expect_at(9, 0, "resettle", F_SETTLE, 16'd0, 2'b00);
      expect_at(10, 0, "stop_settle", F_IDLE, 16'd0, 2'b00);
      tick();
      start = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();

      // Full-scale target with a half-scale step: clamps to FFFF without wrapping.
      start2 = 1'b1;
      expect_at(9,  1, "big_ramp_entry", F_RAMP, 16'h0000, 2'b00);
      expect_at(10, 1, "big_ramp_hold", F_RAMP, 16'h0000, 2'b00);
      expect_at(11, 1, "big_ramp_8000", F_RAMP, 16'h8000, 2'b00);
      expect_at(12, 1, "big_ramp_8000_hold", F_RAMP, 16'h8000, 2'b00);
      expect_at(13, 1, "big_ramp_ffff", F_RAMP, 16'hFFFF, 2'b00);
      expect_at(14, 1, "big_run", F_RUN, 16'hFFFF, 2'b00);
      expect_at(15, 1, "big_stop", F_IDLE, 16'h0000, 2'b00);
      tick();
      start2 = 1'b0;
      repeat (13) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;

      guard = 0;
      while (q.size() > 0 && guard < 100) begin
         tick();
         guard++;
      end
      if (q.size() > 0) begin
         vectors++;
         miscompares++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
